// File: rtl/can_bit_sampler_if.sv
// Bundles the bit-timing inputs and sampled/destuffed outputs of the CAN bit sampler.
// Latency: none (wiring only).
// Backpressure: none; all signals are single-cycle pulses or levels.
interface can_bit_sampler_if;
  // Bus pin and timing inputs from the TQ generator / controller
  logic       can_rx;
  logic       tq_tick;
  logic       sample_point;
  logic       bit_tick;
  logic [4:0] tq_position;
  logic [3:0] tseg1;
  logic [2:0] tseg2;
  logic [1:0] sjw;
  logic       bus_idle;
  logic       destuff_en;

  // Synchronisation feedback and destuffed bit stream
  logic       rx_sync;
  logic       hard_sync;
  logic       resync_valid;
  logic [4:0] resync_adj;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       stuff_seen;
  logic       stuff_err;

  modport master (
    output can_rx, tq_tick, sample_point, bit_tick, tq_position,
           tseg1, tseg2, sjw, bus_idle, destuff_en,
    input  rx_sync, hard_sync, resync_valid, resync_adj,
           rx_bit, rx_bit_valid, stuff_seen, stuff_err
  );

  modport slave (
    input  can_rx, tq_tick, sample_point, bit_tick, tq_position,
           tseg1, tseg2, sjw, bus_idle, destuff_en,
    output rx_sync, hard_sync, resync_valid, resync_adj,
           rx_bit, rx_bit_valid, stuff_seen, stuff_err
  );
endinterface

// File: rtl/can_bit_sampler.sv
// CAN RX synchroniser, edge/phase-error resync logic, bit sampler and stuff-bit remover.
// Latency: rx_sync SYNC_STAGES clks after can_rx; sync pulses and sampled bits 1 clk after their tick.
// Backpressure: none; the consumer must accept every pulse in the cycle it is presented.
module can_bit_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int STUFF_LEN   = 5
) (
  input  logic             clk,
  input  logic             rst,
  can_bit_sampler_if.slave bus
);

  localparam int               CNT_W   = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   prev_level;
  logic                   edge_det;

  logic [5:0]             total_tq;
  logic [5:0]             sample_idx;
  logic [5:0]             pos_ext;
  logic signed [5:0]      phase_err;
  logic signed [5:0]      sjw_lim;
  logic signed [5:0]      adj_clip;

  logic                   hard_sync_q;
  logic                   resync_valid_q;
  logic [4:0]             resync_adj_q;
  logic                   resync_done;

  logic [CNT_W-1:0]       run_cnt;
  logic                   last_bit;
  logic                   rx_bit_q;
  logic                   rx_bit_valid_q;
  logic                   stuff_seen_q;
  logic                   stuff_err_q;

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous pin through the synchroniser chain; idles recessive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.can_rx};
    end
  end

  // Recessive-to-dominant transition seen between two consecutive time quanta
  assign edge_det = bus.tq_tick & prev_level & ~rx_sync;

  // Phase error of the edge relative to the sync segment, clipped to +/-(sjw+1)
  always_comb begin
    total_tq   = {2'b00, bus.tseg1} + {3'b000, bus.tseg2} + 6'd3;
    sample_idx = {2'b00, bus.tseg1} + 6'd2;
    pos_ext    = {1'b0, bus.tq_position};
    sjw_lim    = $signed({4'b0000, bus.sjw} + 6'd1);
    if (pos_ext <= sample_idx) begin
      phase_err = $signed(pos_ext - 6'd1);
    end else begin
      phase_err = $signed(pos_ext - total_tq - 6'd1);
    end
    adj_clip = phase_err;
    if (phase_err > sjw_lim) begin
      adj_clip = sjw_lim;
    end else if (phase_err < -sjw_lim) begin
      adj_clip = -sjw_lim;
    end
  end

  // Hard sync on idle bus, at most one resync per bit otherwise; bit_tick re-arms resync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_level     <= 1'b1;
      hard_sync_q    <= 1'b0;
      resync_valid_q <= 1'b0;
      resync_adj_q   <= '0;
      resync_done    <= 1'b0;
    end else begin
      hard_sync_q    <= 1'b0;
      resync_valid_q <= 1'b0;
      if (bus.tq_tick) begin
        prev_level <= rx_sync;
      end
      if (edge_det) begin
        if (bus.bus_idle) begin
          hard_sync_q <= 1'b1;
          resync_done <= 1'b1;
        end else if (!resync_done && (phase_err != 6'sd0)) begin
          resync_valid_q <= 1'b1;
          resync_adj_q   <= adj_clip[4:0];
          resync_done    <= 1'b1;
        end
      end
      // Placed last so a clear in the same cycle as an edge takes priority
      if (bus.bit_tick) begin
        resync_done <= 1'b0;
      end
    end
  end

  // Sample once per bit and drop/flag the bit following a run of STUFF_LEN equal bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt        <= '0;
      last_bit       <= 1'b1;
      rx_bit_q       <= 1'b1;
      rx_bit_valid_q <= 1'b0;
      stuff_seen_q   <= 1'b0;
      stuff_err_q    <= 1'b0;
    end else begin
      rx_bit_valid_q <= 1'b0;
      stuff_seen_q   <= 1'b0;
      stuff_err_q    <= 1'b0;
      if (bus.sample_point) begin
        if (!bus.destuff_en) begin
          rx_bit_q       <= rx_sync;
          rx_bit_valid_q <= 1'b1;
          run_cnt        <= '0;
          last_bit       <= rx_sync;
        end else if (run_cnt < RUN_MAX) begin
          run_cnt        <= (rx_sync == last_bit) ? run_cnt + RUN_ONE : RUN_ONE;
          last_bit       <= rx_sync;
          rx_bit_q       <= rx_sync;
          rx_bit_valid_q <= 1'b1;
        end else begin
          if (rx_sync != last_bit) begin
            stuff_seen_q <= 1'b1;
          end else begin
            stuff_err_q  <= 1'b1;
          end
          run_cnt  <= RUN_ONE;
          last_bit <= rx_sync;
        end
      end
    end
  end

  assign bus.rx_sync      = rx_sync;
  assign bus.hard_sync    = hard_sync_q;
  assign bus.resync_valid = resync_valid_q;
  assign bus.resync_adj   = resync_adj_q;
  assign bus.rx_bit       = rx_bit_q;
  assign bus.rx_bit_valid = rx_bit_valid_q;
  assign bus.stuff_seen   = stuff_seen_q;
  assign bus.stuff_err    = stuff_err_q;

endmodule
